// File: rtl/i2c_txn_arbiter_pkg.sv
// i2c_pkg: shared widths and FSM state encoding for the I2C transaction arbiter
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE} arb_state_e;
endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// i2c_txn_arbiter_if: command/status link between the arbiter (master) and the I2C driver (slave)
interface i2c_txn_arbiter_if;
    import i2c_pkg::*;
    logic                  drv_start;
    logic                  drv_rw;
    logic [I2C_ADDR_W-1:0] drv_addr;
    logic [I2C_DATA_W-1:0] drv_wdata;
    logic                  drv_busy;
    logic [I2C_DATA_W-1:0] drv_rdata;
    modport master (output drv_start, drv_rw, drv_addr, drv_wdata, input drv_busy, drv_rdata);
    modport slave (input drv_start, drv_rw, drv_addr, drv_wdata, output drv_busy, drv_rdata);
endinterface

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick; ptr is the highest-priority index (one past the last grant)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[PW'((int'(ptr) + i) % N)]) begin
                gnt = '0;
                gnt[PW'((int'(ptr) + i) % N)] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter serialising requester transactions onto one I2C driver
// Define I2C_ARB_TIMEOUT_EN to add busy-rise/transfer timeouts that complete with err.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BUSY_WAIT = 64,
    parameter int XFER_MAX  = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic                          err,
    output logic [I2C_DATA_W-1:0]         rdata,
    i2c_txn_arbiter_if.master             drv
);
    localparam int PW = $clog2(NUM_REQ);
    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d, done_q, done_d, pick;
    logic [I2C_DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d, sel_wdata;
    logic [I2C_ADDR_W-1:0] addr_q, addr_d, sel_addr;
    logic                  rw_q, rw_d, sel_rw, tmo;
    logic [PW-1:0]         ptr_q, ptr_d, win;

    rr_arbiter #(.N(NUM_REQ)) u_rr (.req(req), .ptr(ptr_q), .gnt(pick));

    always_comb begin
        win       = '0;
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                win       = PW'(i);
                sel_rw    = req_rw[i];
                sel_addr  = req_addr[I2C_ADDR_W*i +: I2C_ADDR_W];
                sel_wdata = req_wdata[I2C_DATA_W*i +: I2C_DATA_W];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        err_q;
    // A timeout only fires when the normal exit of that state did not happen this cycle
    assign tmo = (state_q == WAIT_BUSY && !drv.drv_busy && cnt_q == 32'(BUSY_WAIT - 1)) ||
                 (state_q == WAIT_DONE &&  drv.drv_busy && cnt_q == 32'(XFER_MAX - 1));
    assign cnt_d = (state_d == state_q && (state_q == WAIT_BUSY || state_q == WAIT_DONE)) ? cnt_q + 1'b1 : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= tmo;
        end
    end
    assign err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{BUSY_WAIT, XFER_MAX};
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = ISSUE;
                gnt_d   = pick;
                rw_d    = sel_rw;
                addr_d  = sel_addr;
                wdata_d = sel_wdata;
                ptr_d   = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: state_d = drv.drv_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: if (!drv.drv_busy) begin
                state_d = COMPLETE;
                rdata_d = rw_q ? drv.drv_rdata : rdata_q;
            end
            default:   state_d = IDLE;
        endcase
        if (tmo) state_d = COMPLETE;
        // Grant drops as done is raised, so both land in the COMPLETE cycle
        if (state_d == COMPLETE && state_q != COMPLETE) begin
            gnt_d  = '0;
            done_d = gnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign rdata         = rdata_q;
    assign drv.drv_start = (state_q == ISSUE);
    assign drv.drv_rw    = rw_q;
    assign drv.drv_addr  = addr_q;
    assign drv.drv_wdata = wdata_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: directed self-checking bench for i2c_txn_arbiter (timeout expectations follow I2C_ARB_TIMEOUT_EN)
module tb_i2c_txn_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req, req_rw, gnt, done;
    logic [27:0] req_addr;
    logic [31:0] req_wdata;
    logic        err;
    logic [7:0]  rdata;
    int          checks = 0;
    int          errors = 0;

    i2c_txn_arbiter_if drv_if();

    i2c_txn_arbiter #(.NUM_REQ(4), .BUSY_WAIT(8), .XFER_MAX(65535)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata), .drv(drv_if)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in WAIT_BUSY; returns at the negedge of the COMPLETE cycle
    task automatic serve(input logic [7:0] rd);
        drv_if.drv_busy  = 1'b1;
        drv_if.drv_rdata = rd;
        cyc(2);
        drv_if.drv_busy = 1'b0;
        cyc(1);
    endtask

    initial begin
        req = '0;
        req_rw = '0;
        req_addr = '0;
        req_wdata = '0;
        drv_if.drv_busy = 1'b0;
        drv_if.drv_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[7*i +: 7]  = 7'(16 + i);
            req_wdata[8*i +: 8] = 8'(160 + i);
        end
        cyc(2);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_start", drv_if.drv_start, 0);
        chk("rst_rw", drv_if.drv_rw, 0);
        chk("rst_addr", drv_if.drv_addr, 0);
        chk("rst_wdata", drv_if.drv_wdata, 0);
        rst_n = 1'b1;
        cyc(1);
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("cont_gnt", gnt, 32'(1 << (k % 4)));
            chk("cont_start", drv_if.drv_start, 1);
            chk("cont_addr", drv_if.drv_addr, 32'(16 + k % 4));
            cyc(1);
            serve(8'h00);
            chk("cont_done", done, 32'(1 << (k % 4)));
            chk("cont_gnt_clr", gnt, 0);
            cyc(1);
            chk("cont_done_pulse", done, 0);
        end
        req = '0;
        req_addr[6:0] = 7'h50;
        req_wdata[7:0] = 8'hA5;
        req = 4'b0001;
        cyc(1);
        chk("wr_gnt", gnt, 4'b0001);
        chk("wr_start", drv_if.drv_start, 1);
        chk("wr_addr", drv_if.drv_addr, 32'h50);
        chk("wr_wdata", drv_if.drv_wdata, 32'hA5);
        chk("wr_rw", drv_if.drv_rw, 0);
        cyc(1);
        chk("wr_start_one", drv_if.drv_start, 0);
        serve(8'h77);
        chk("wr_done", done, 4'b0001);
        chk("wr_err", err, 0);
        chk("wr_rdata_keep", rdata, 0);
        req = '0;
        cyc(1);
        chk("wr_done_pulse", done, 0);
        req_rw = 4'b0100;
        req = 4'b0100;
        cyc(1);
        chk("rd_gnt", gnt, 4'b0100);
        chk("rd_rw", drv_if.drv_rw, 1);
        chk("rd_addr", drv_if.drv_addr, 32'h12);
        cyc(1);
        serve(8'h3C);
        chk("rd_done", done, 4'b0100);
        chk("rd_rdata", rdata, 32'h3C);
        req = '0;
        req_rw = '0;
        cyc(1);
        req = 4'b0010;
        cyc(1);
        chk("mid_gnt", gnt, 4'b0010);
        chk("mid_addr0", drv_if.drv_addr, 32'h11);
        cyc(1);
        drv_if.drv_busy = 1'b1;
        cyc(1);
        req_addr[13:7] = 7'h44;
        req = '0;
        drv_if.drv_rdata = 8'h99;
        cyc(1);
        chk("mid_addr_hold", drv_if.drv_addr, 32'h11);
        chk("mid_gnt_hold", gnt, 4'b0010);
        drv_if.drv_busy = 1'b0;
        cyc(1);
        chk("mid_done", done, 4'b0010);
        chk("mid_rdata_keep", rdata, 32'h3C);
        cyc(1);
        req = 4'b1000;
        cyc(1);
        chk("to_gnt", gnt, 4'b1000);
        cyc(1);
        cyc(7);
        chk("to_early", done, 0);
        cyc(1);
`ifdef I2C_ARB_TIMEOUT_EN
        chk("to_done", done, 4'b1000);
        chk("to_err", err, 1);
        chk("to_rdata_keep", rdata, 32'h3C);
        req = '0;
        cyc(1);
        chk("to_err_pulse", err, 0);
`else
        chk("nto_done", done, 0);
        chk("nto_gnt", gnt, 4'b1000);
        chk("nto_err", err, 0);
        serve(8'h00);
        chk("nto_done_late", done, 4'b1000);
        req = '0;
        cyc(1);
`endif
        req = 4'b0001;
        cyc(1);
        cyc(1);
        drv_if.drv_busy = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_done", done, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_addr", drv_if.drv_addr, 0);
        chk("arst_wdata", drv_if.drv_wdata, 0);
        chk("arst_start", drv_if.drv_start, 0);
        req = '0;
        drv_if.drv_busy = 1'b0;
        cyc(1);
        chk("arst_no_done", done, 0);
        rst_n = 1'b1;
        req = 4'b0010;
        cyc(1);
        chk("post_gnt", gnt, 4'b0010);
        chk("post_start", drv_if.drv_start, 1);
        chk("post_addr", drv_if.drv_addr, 32'h44);
        cyc(1);
        serve(8'h00);
        chk("post_done", done, 4'b0010);
        req = '0;
        cyc(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
